// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: program counter, word fetch to instruction memory, prefetch FIFO
// of {instr, pc} handed to decode. A redirect flushes the FIFO and restarts fetch.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high
  // (imem_req/imem_gnt, id_valid/id_ready). A request is held stable until granted
  // unless a redirect or reset withdraws it; imem_rdata is valid the cycle after a grant.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   out_pc_q;
  logic          outstanding_q;
  logic          kill_q;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic          accept;
  logic          deq;
  logic          wr_en;
  logic [CW:0]   occ;

  // Occupancy as seen next cycle: buffered words plus the one in flight, minus the one leaving.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, outstanding_q} - {{CW{1'b0}}, deq};
  assign imem_req = reset & ~redirect & (occ < DEPTH_C);
  assign imem_addr = pc_q;
  assign accept   = imem_req & imem_gnt;

  assign id_valid = (count != '0);
  assign deq      = id_valid & id_ready;
  assign id_instr = id_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign id_pc    = id_valid ? fifo_pc[rd_ptr]    : 32'h0;

  // A response arriving alongside a redirect belongs to the old stream and is dropped.
  assign wr_en = outstanding_q & ~kill_q & ~redirect;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      out_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else if (redirect) begin
      pc_q          <= {redirect_pc[31:2], 2'b00};
      outstanding_q <= accept;
      kill_q        <= accept;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else begin
      outstanding_q <= accept;
      kill_q        <= 1'b0;
      if (accept) begin
        pc_q     <= pc_q + 32'd4;
        out_pc_q <= pc_q;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (deq)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count marks them valid.
  always_ff @(posedge clk) begin
    if (reset && !redirect && wr_en) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= out_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: steady fetch, back-pressure, grant stall,
// redirect flush, PC wrap (second instance) and mid-stream reset.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_gnt;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  logic        w_req;
  logic [31:0] w_addr, w_rdata;
  logic        w_valid;
  logic [31:0] w_instr, w_pc;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_instr), .id_pc(w_pc)
  );

  // Memory model: word at address A holds A>>2; garbage when nothing was accepted.
  always @(posedge clk) begin
    imem_rdata <= (imem_req && imem_gnt) ? (imem_addr >> 2) : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? (w_addr >> 2) : 32'hDEAD_BEEF;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    check({tag, "_valid"}, {31'b0, id_valid}, {31'b0, v});
    check({tag, "_pc"},    id_pc,    pc);
    check({tag, "_instr"}, id_instr, instr);
  endtask

  task automatic check_req(input string tag, input logic r, input logic [31:0] addr);
    check({tag, "_req"},  {31'b0, imem_req}, {31'b0, r});
    check({tag, "_addr"}, imem_addr, addr);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    cyc(); cyc(); settle();
    check_req("rst", 1'b0, 32'h0);
    check_id("rst", 1'b0, 32'h0, 32'h0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

    // C0: first cycle out of reset
    reset = 1'b1; settle();
    check_req("c0", 1'b1, 32'h0);
    check("c0_wrap_addr", w_addr, 32'hFFFF_FFF8);
    cyc(); settle();                         // C1
    check_req("c1", 1'b1, 32'h4);
    check_id("c1", 1'b0, 32'h0, 32'h0);
    check("c1_wrap_addr", w_addr, 32'hFFFF_FFFC);
    cyc(); settle();                         // C2
    check_req("c2", 1'b1, 32'h8);
    check_id("c2", 1'b1, 32'h0, 32'h0);
    check("c2_wrap_addr", w_addr, 32'h0000_0000);
    check("c2_wrap_pc", w_pc, 32'hFFFF_FFF8);
    check("c2_wrap_instr", w_instr, 32'h3FFF_FFFE);
    cyc(); settle();                         // C3
    check_req("c3", 1'b1, 32'hC);
    check_id("c3", 1'b1, 32'h4, 32'h1);
    cyc();                                   // C4: back-pressure for 5 cycles
    id_ready = 1'b0; settle();
    check_req("bp0", 1'b0, 32'h10);
    check_id("bp0", 1'b1, 32'h8, 32'h2);
    for (int i = 1; i < 5; i++) begin        // C5..C8
      cyc(); settle();
      check_req("bp", 1'b0, 32'h10);
      check_id("bp", 1'b1, 32'h8, 32'h2);
    end

    cyc();                                   // C9: release ready, grant low for 3 cycles
    id_ready = 1'b1; imem_gnt = 1'b0; settle();
    check_req("gs0", 1'b1, 32'h10);
    check_id("gs0", 1'b1, 32'h8, 32'h2);
    cyc(); settle();                         // C10
    check_req("gs1", 1'b1, 32'h10);
    check_id("gs1", 1'b1, 32'hC, 32'h3);
    cyc(); settle();                         // C11
    check_req("gs2", 1'b1, 32'h10);
    check_id("gs2", 1'b0, 32'h0, 32'h0);
    cyc();                                   // C12: grant
    imem_gnt = 1'b1; settle();
    check_req("g0", 1'b1, 32'h10);
    check_id("g0", 1'b0, 32'h0, 32'h0);
    cyc(); settle();                         // C13
    check_req("g1", 1'b1, 32'h14);
    check_id("g1", 1'b0, 32'h0, 32'h0);
    cyc(); settle();                         // C14
    check_req("g2", 1'b1, 32'h18);
    check_id("g2", 1'b1, 32'h10, 32'h4);

    cyc();                                   // C15: redirect while word for 0x18 returns
    redirect = 1'b1; redirect_pc = 32'h0000_0103; settle();
    check("rd0_req", {31'b0, imem_req}, 32'h0);
    check_id("rd0", 1'b1, 32'h14, 32'h5);
    cyc();                                   // C16
    redirect = 1'b0; settle();
    check_req("rd1", 1'b1, 32'h100);
    check_id("rd1", 1'b0, 32'h0, 32'h0);
    cyc(); settle();                         // C17
    check_req("rd2", 1'b1, 32'h104);
    check_id("rd2", 1'b0, 32'h0, 32'h0);
    cyc(); settle();                         // C18
    check_id("rd3", 1'b1, 32'h100, 32'h40);
    cyc(); settle();                         // C19
    check_id("rd4", 1'b1, 32'h104, 32'h41);

    cyc();                                   // C20: reset pulse with a fetch outstanding
    reset = 1'b0; settle();
    check("mr0_req", {31'b0, imem_req}, 32'h0);
    cyc();                                   // C21
    reset = 1'b1; settle();
    check_req("mr1", 1'b1, 32'h0);
    check_id("mr1", 1'b0, 32'h0, 32'h0);
    cyc(); settle();                         // C22
    check_req("mr2", 1'b1, 32'h4);
    check_id("mr2", 1'b0, 32'h0, 32'h0);
    cyc(); settle();                         // C23
    check_id("mr3", 1'b1, 32'h0, 32'h0);
    cyc(); settle();                         // C24
    check_id("mr4", 1'b1, 32'h4, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
